// File: rtl/wb_streamer_pkg.sv
// rtl/wb_streamer_pkg.sv - shared widths and helpers for the Wishbone stream writer
//
// Purpose : default data/packet-length widths and the FIFO capacity helper
//           used by the stream writer FIFO and its storage array.
// Ports   : none (package).
package wb_streamer_pkg;

  localparam int DEF_WB_DW = 32;
  localparam int PKT_LEN_W = 16;

  // Number of words held by a FIFO addressed with aw bits.
  function automatic int unsigned fifo_capacity(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/wb_stream_fifo_mem.sv
// rtl/wb_stream_fifo_mem.sv - 2**AW x DW storage, synchronous write, asynchronous read
//
// Purpose : backing store for the stream writer FIFO. Written as a plain
//           array with a combinational read so it maps onto distributed RAM.
//           No reset: contents are only meaningful between the pointers kept
//           by the parent.
// Ports   : i_clk    clock
//           i_we     write enable
//           i_waddr  write address (AW bits)
//           i_wdata  write data (DW bits)
//           i_raddr  read address (AW bits)
//           o_rdata  read data, combinational from i_raddr
module wb_stream_fifo_mem
  import wb_streamer_pkg::*;
#(
  parameter int DW = DEF_WB_DW,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned LP_DEPTH = fifo_capacity(AW);

  logic [DW-1:0] r_mem [0:LP_DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/wb_stream_writer_fifo.sv
// rtl/wb_stream_writer_fifo.sv - word FIFO draining onto a valid/ready stream master
//
// Purpose : buffers words written by the Wishbone stream writer controller and
//           presents them on a stream master port. Storage is a memory plus a
//           show-ahead output register; fifo_cnt counts both and tops out at
//           2**FIFO_AW. Optional packet framing drives stream_m_last_o.
// Config  : define WB_STREAM_WRITER_FIFO_LAST_EN to enable the packet counter
//           and last flag; otherwise stream_m_last_o is 0 and pkt_len unused.
// Ports   : wb_clk_i          clock
//           wb_rst_i          asynchronous active-high reset
//           fifo_d            write data
//           fifo_wr           write strobe, one word per cycle
//           fifo_cnt          occupancy (FIFO_AW+1 bits)
//           clr               synchronous flush
//           overflow          sticky, write attempted while full
//           pkt_len           words per packet, 0 = unframed
//           stream_m_data_o   output data
//           stream_m_valid_o  output valid
//           stream_m_ready_i  sink ready
//           stream_m_last_o   last word of packet
module wb_stream_writer_fifo
  import wb_streamer_pkg::*;
#(
  parameter int WB_DW   = DEF_WB_DW,
  parameter int FIFO_AW = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [WB_DW-1:0]     fifo_d,
  input  logic                 fifo_wr,
  output logic [FIFO_AW:0]     fifo_cnt,
  input  logic                 clr,
  output logic                 overflow,
  input  logic [PKT_LEN_W-1:0] pkt_len,
  output logic [WB_DW-1:0]     stream_m_data_o,
  output logic                 stream_m_valid_o,
  input  logic                 stream_m_ready_i,
  output logic                 stream_m_last_o
);

  if (FIFO_AW < 1) begin : g_bad_fifo_aw
    $error("wb_stream_writer_fifo: FIFO_AW must be >= 1");
  end

  localparam int unsigned      LP_CAP     = fifo_capacity(FIFO_AW);
  localparam logic [FIFO_AW:0] LP_CAP_CNT = LP_CAP[FIFO_AW:0];

  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_cnt;
  logic               r_valid;
  logic [WB_DW-1:0]   r_data;
  logic               r_overflow;

  logic               w_full;
  logic               w_wr_acc;
  logic               w_rd;
  logic [FIFO_AW:0]   w_mem_cnt;
  logic               w_mem_empty;
  logic               w_load;
  logic               w_bypass;
  logic               w_pop;
  logic               w_mem_we;
  logic [WB_DW-1:0]   w_mem_rdata;

  // Full is judged on the registered count, so a write in the same cycle as
  // a read of a full FIFO is still dropped.
  assign w_full    = (r_cnt == LP_CAP_CNT);
  assign w_wr_acc  = fifo_wr && !w_full;
  assign w_rd      = r_valid && stream_m_ready_i;

  // Words sitting in the memory, i.e. everything except the output register.
  assign w_mem_cnt   = r_cnt - {{FIFO_AW{1'b0}}, r_valid};
  assign w_mem_empty = (w_mem_cnt == '0);

  // The output register can take a new word when it is empty or being read.
  // With the memory empty, an accepted write goes straight to the output
  // register so a single word appears the cycle after it is written. With
  // the memory non-empty the oldest memory word is promoted instead, which
  // keeps order and gives back-to-back words with no bubble.
  assign w_load   = !r_valid || w_rd;
  assign w_bypass = w_load && w_mem_empty && w_wr_acc;
  assign w_pop    = w_load && !w_mem_empty;
  assign w_mem_we = w_wr_acc && !w_bypass;

  wb_stream_fifo_mem #(
    .DW (WB_DW),
    .AW (FIFO_AW)
  ) u_mem (
    .i_clk   (wb_clk_i),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (fifo_d),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (fifo_wr && w_full) begin
        r_overflow <= 1'b1;
      end

      if (w_mem_we) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end

      if (w_pop) begin
        r_data   <= w_mem_rdata;
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
        r_valid  <= 1'b1;
      end else if (w_bypass) begin
        r_data  <= fifo_d;
        r_valid <= 1'b1;
      end else if (w_rd) begin
        r_valid <= 1'b0;
      end

      case ({w_wr_acc, w_rd})
        2'b10:   r_cnt <= r_cnt + (FIFO_AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (FIFO_AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign fifo_cnt         = r_cnt;
  assign overflow         = r_overflow;
  assign stream_m_valid_o = r_valid;
  assign stream_m_data_o  = r_data;

`ifdef WB_STREAM_WRITER_FIFO_LAST_EN
  logic [PKT_LEN_W-1:0] r_pkt_cnt;
  logic                 w_pkt_end;

  // r_pkt_cnt is the index within the packet of the word currently presented;
  // it only moves on a handshake so last stays stable under backpressure.
  assign w_pkt_end = (pkt_len != '0) && (r_pkt_cnt == pkt_len - PKT_LEN_W'(1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_pkt_cnt <= '0;
    end else if (clr || (pkt_len == '0)) begin
      r_pkt_cnt <= '0;
    end else if (w_rd) begin
      r_pkt_cnt <= w_pkt_end ? '0 : r_pkt_cnt + PKT_LEN_W'(1);
    end
  end

  assign stream_m_last_o = r_valid && w_pkt_end;
`else
  logic w_unused_pkt_len;

  assign w_unused_pkt_len = ^pkt_len;
  assign stream_m_last_o  = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stream_writer_fifo.sv
// tb/tb_wb_stream_writer_fifo.sv - scoreboard bench for wb_stream_writer_fifo
module tb_wb_stream_writer_fifo;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] fifo_d = '0;
  logic          fifo_wr = 1'b0;
  logic [AW:0]   fifo_cnt;
  logic          clr = 1'b0;
  logic          overflow;
  logic [15:0]   pkt_len = '0;
  logic [DW-1:0] sdata;
  logic          svalid;
  logic          sready = 1'b0;
  logic          slast;

  always #5 clk = ~clk;

  wb_stream_writer_fifo #(
    .WB_DW   (DW),
    .FIFO_AW (AW)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .fifo_d           (fifo_d),
    .fifo_wr          (fifo_wr),
    .fifo_cnt         (fifo_cnt),
    .clr              (clr),
    .overflow         (overflow),
    .pkt_len          (pkt_len),
    .stream_m_data_o  (sdata),
    .stream_m_valid_o (svalid),
    .stream_m_ready_i (sready),
    .stream_m_last_o  (slast)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: sb holds every word currently inside the FIFO, oldest
  // first. The driver pushes accepted words; the monitor pops on handshakes.
  logic [DW-1:0] sb[$];
  int            pend    = 0;    // word pushed this cycle, not yet visible
  bit            ovf_evt = 1'b0; // write dropped this cycle
  bit            m_ovf   = 1'b0;
  int            m_words = 0;    // handshakes since last clr/reset
  bit            mon_en  = 1'b0;
  int            last_idx[$];

  bit            p_valid = 1'b0;
  bit            p_ready = 1'b0;
  bit            p_clr   = 1'b0;
  bit            p_last  = 1'b0;
  logic [DW-1:0] p_data  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // One clock cycle of stimulus; the acceptance decision uses the model's
  // occupancy before the edge.
  task automatic drive(input logic wr, input logic [DW-1:0] d, input logic rdy, input logic c);
    @(posedge clk);
    #2;
    fifo_wr = wr;
    fifo_d  = d;
    sready  = rdy;
    clr     = c;
    pend    = 0;
    ovf_evt = 1'b0;
    if (!c && wr) begin
      if (sb.size() < CAP) begin
        sb.push_back(d);
        pend = 1;
      end else begin
        ovf_evt = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    int occ;
    bit exp_last;
    if (mon_en) begin
      occ = sb.size() - pend;
      chk("cnt", 32'(fifo_cnt), occ);
      chk("valid", 32'(svalid), 32'(occ != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (p_valid && !p_ready && !p_clr) begin
        chk("stall_valid", 32'(svalid), 32'd1);
        chk("stall_data", sdata, p_data);
        chk("stall_last", 32'(slast), 32'(p_last));
      end
      if (svalid) begin
`ifdef WB_STREAM_WRITER_FIFO_LAST_EN
        exp_last = (pkt_len != 0) && ((m_words % int'(pkt_len)) == int'(pkt_len) - 1);
`else
        exp_last = 1'b0;
`endif
        chk("last", 32'(slast), 32'(exp_last));
      end
      p_valid = svalid;
      p_ready = sready;
      p_clr   = clr;
      p_last  = slast;
      p_data  = sdata;
      if (clr) begin
        sb.delete();
        m_ovf   = 1'b0;
        m_words = 0;
      end else begin
        if (svalid && sready && occ > 0) begin
          chk("data", sdata, sb[0]);
          void'(sb.pop_front());
          if (slast) last_idx.push_back(m_words);
          m_words++;
        end
        if (ovf_evt) m_ovf = 1'b1;
      end
      pend    = 0;
      ovf_evt = 1'b0;
    end
  end

  initial begin : stim
    int n;
    int cyc;
    logic w;

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_valid", 32'(svalid), 32'd0);
    chk("rst_data", sdata, 32'd0);
    chk("rst_last", 32'(slast), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    mon_en = 1'b1;

    // Single word with the sink ready.
    drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Fill past capacity with the sink stalled, then drain.
    for (int i = 0; i < 17; i++) drive(1'b1, 32'h1000_0000 + i, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_cnt", 32'(fifo_cnt), 32'd16);
    chk("full_overflow", 32'(overflow), 32'd1);
    repeat (20) drive(1'b0, '0, 1'b1, 1'b0);
    chk("drain_model_empty", sb.size(), 32'd0);
    chk("drain_valid", 32'(svalid), 32'd0);

    // Concurrent write/read at a steady occupancy of 8.
    for (int i = 0; i < 8; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b1, $urandom, 1'b1, 1'b0);
    repeat (12) drive(1'b0, '0, 1'b1, 1'b0);

    // Flush with a simultaneous write at occupancy 5.
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    chk("clr_cnt", 32'(fifo_cnt), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);

    // Random backpressure over 1000 written words.
    n = 0;
    cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      w = ($urandom_range(0, 3) != 0);
      drive(w, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      if (w) n++;
      cyc++;
    end
    chk("bp_words", n, 32'd1000);
    repeat (20) drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_model_empty", sb.size(), 32'd0);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 10; i++) drive(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    @(posedge clk);
    #1;
    mon_en  = 1'b0;
    rst     = 1'b1;
    fifo_wr = 1'b0;
    clr     = 1'b0;
    sb.delete();
    pend    = 0;
    ovf_evt = 1'b0;
    m_ovf   = 1'b0;
    m_words = 0;
    p_valid = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("mid_rst_valid", 32'(svalid), 32'd0);
    chk("mid_rst_data", sdata, 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Packet framing, pkt_len = 4 over 12 words.
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    pkt_len = 16'd4;
    last_idx.delete();
    for (int i = 0; i < 12; i++) drive(1'b1, 32'h4000_0000 + i, 1'($urandom_range(0, 1)), 1'b0);
    repeat (20) drive(1'b0, '0, 1'b1, 1'b0);
    chk("pkt_words", m_words, 32'd12);
`ifdef WB_STREAM_WRITER_FIFO_LAST_EN
    chk("last_count", last_idx.size(), 32'd3);
    if (last_idx.size() == 3) begin
      chk("last_pos0", last_idx[0], 32'd3);
      chk("last_pos1", last_idx[1], 32'd7);
      chk("last_pos2", last_idx[2], 32'd11);
    end
`else
    chk("last_count", last_idx.size(), 32'd0);
`endif

    // Unframed: pkt_len = 0 never raises last.
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    pkt_len = 16'd0;
    last_idx.delete();
    for (int i = 0; i < 12; i++) drive(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    repeat (20) drive(1'b0, '0, 1'b1, 1'b0);
    chk("nolast_count", last_idx.size(), 32'd0);

    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
